// File: rtl/systol_fifo_bank_if.sv
// Bus bundle for systol_fifo_bank: per-lane write/read requests, packed lane data and status.
// SYSTOL_FIFO_PROG_FLAGS_EN adds the prog_full/prog_empty lanes.
interface systol_fifo_bank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int CHANNELS   = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CHANNELS*DATA_WIDTH-1:0] din;
  logic [CHANNELS-1:0]            wr_en;
  logic [CHANNELS-1:0]            rd_en;
  logic                           rd_all;
  logic [CHANNELS*DATA_WIDTH-1:0] dout;
  logic [CHANNELS-1:0]            data_valid;
  logic [CHANNELS-1:0]            full;
  logic [CHANNELS-1:0]            empty;
  logic [CHANNELS*CW-1:0]         data_count;
  logic [CHANNELS-1:0]            overflow;
  logic [CHANNELS-1:0]            underflow;
  logic                           rst_busy;
`ifdef SYSTOL_FIFO_PROG_FLAGS_EN
  logic [CHANNELS-1:0]            prog_full;
  logic [CHANNELS-1:0]            prog_empty;
`endif

  modport master (
    output din, wr_en, rd_en, rd_all,
    input  dout, data_valid, full, empty, data_count, overflow, underflow, rst_busy
`ifdef SYSTOL_FIFO_PROG_FLAGS_EN
    , input prog_full, prog_empty
`endif
  );

  modport slave (
    input  din, wr_en, rd_en, rd_all,
    output dout, data_valid, full, empty, data_count, overflow, underflow, rst_busy
`ifdef SYSTOL_FIFO_PROG_FLAGS_EN
    , output prog_full, prog_empty
`endif
  );
endinterface

// File: rtl/systol_fifo_bank.sv
// Bank of CHANNELS synchronous FIFOs, read latency 1, lane-aligned rd_all; full lanes drop writes, empty lanes drop reads.
// Optional programmable flags under SYSTOL_FIFO_PROG_FLAGS_EN.
module systol_fifo_bank #(
  parameter int DATA_WIDTH      = 32,
  parameter int DEPTH           = 16,
  parameter int CHANNELS        = 16,
  parameter int RST_BUSY_CYCLES = 4
`ifdef SYSTOL_FIFO_PROG_FLAGS_EN
  , parameter int PROG_FULL_THRESH  = DEPTH - 2
  , parameter int PROG_EMPTY_THRESH = 2
`endif
) (
  input  logic               fifo_clk,
  input  logic               fifo_rst,
  systol_fifo_bank_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (RST_BUSY_CYCLES > 0) ? $clog2(RST_BUSY_CYCLES + 1) : 1;

  logic [DATA_WIDTH-1:0]          mem [CHANNELS][DEPTH];
  logic [AW-1:0]                  wr_ptr [CHANNELS];
  logic [AW-1:0]                  rd_ptr [CHANNELS];
  logic [CW-1:0]                  count [CHANNELS];
  logic [CHANNELS*DATA_WIDTH-1:0] dout_q;
  logic [CHANNELS-1:0]            valid_q, ovf_q, unf_q;
  logic [CHANNELS-1:0]            full_w, empty_w, wr_acc, rd_req, rd_acc;
  logic                           busy;
  logic [BW-1:0]                  busy_cnt;
  logic                           all_rdy;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign full_w[g]  = (count[g] == CW'(DEPTH));
    assign empty_w[g] = (count[g] == '0);
    assign bus.data_count[g*CW +: CW] = count[g];
`ifdef SYSTOL_FIFO_PROG_FLAGS_EN
    assign bus.prog_full[g]  = (count[g] >= CW'(PROG_FULL_THRESH));
    assign bus.prog_empty[g] = (count[g] <= CW'(PROG_EMPTY_THRESH));
`endif
  end

  // An aligned read fires only when every lane can supply a word.
  assign all_rdy = ~|empty_w & ~busy;
  assign wr_acc  = bus.wr_en & ~full_w & {CHANNELS{~busy}};
  assign rd_req  = bus.rd_all ? {CHANNELS{1'b1}} : bus.rd_en;
  assign rd_acc  = bus.rd_all ? {CHANNELS{all_rdy}}
                              : (bus.rd_en & ~empty_w & {CHANNELS{~busy}});

  always_ff @(posedge fifo_clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (!fifo_rst && wr_acc[i]) begin
        mem[i][wr_ptr[i]] <= bus.din[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge fifo_clk) begin
    if (fifo_rst) begin
      busy     <= 1'b1;
      busy_cnt <= BW'(RST_BUSY_CYCLES);
      dout_q   <= '0;
      valid_q  <= '0;
      ovf_q    <= '0;
      unf_q    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      // busy drops on the edge that consumes the last busy cycle
      if (busy_cnt != '0) busy_cnt <= busy_cnt - 1'b1;
      busy    <= (busy_cnt > BW'(1));
      valid_q <= rd_acc;
      ovf_q   <= bus.wr_en & full_w & {CHANNELS{~busy}};
      unf_q   <= rd_req & empty_w & {CHANNELS{~busy}};
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_acc[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (rd_acc[i]) begin
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
          dout_q[i*DATA_WIDTH +: DATA_WIDTH] <= mem[i][rd_ptr[i]];
        end
        case ({wr_acc[i], rd_acc[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.data_valid = valid_q;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = unf_q;
  assign bus.full       = full_w;
  assign bus.empty      = empty_w;
  assign bus.rst_busy   = busy;
endmodule
